// File: rtl/mem_access_fsm.sv
// LDR/STR memory access sequencer: latches a request, runs a bus request/acknowledge
// handshake with programmable wait states and a timeout, and returns load data.
module mem_access_fsm #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 15,
    parameter logic [3:0]  OP_LDR      = 4'b1101,
    parameter logic [3:0]  OP_STR      = 4'b1110
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [3:0]        Opcode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data,
    input  logic [DATA_W-1:0] Din,
    input  logic              BusAck,
    output logic              BusReq,
    output logic [ADDR_W-1:0] AddressBus,
    output logic              AddressBusSel,
    output logic              RW,
    output logic [DATA_W-1:0] Dout,
    output logic [DATA_W-1:0] LDRDataToDestReg,
    output logic              LDRSel,
    output logic              Busy,
    output logic              Done,
    output logic              Error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LOAD = 8'(TIMEOUT);
    localparam logic [7:0] WAIT_LOAD    = 8'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

    state_t     state_r;
    logic       is_ldr_r;
    logic [7:0] timeout_cnt_r;
    logic [7:0] wait_cnt_r;

    // Sequencer: next state and every output are registered together.
    // AddressBus and Dout double as the address/store-data latches while the bus is driven.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r          <= ST_IDLE;
            is_ldr_r         <= 1'b0;
            timeout_cnt_r    <= 8'd0;
            wait_cnt_r       <= 8'd0;
            BusReq           <= 1'b0;
            AddressBus       <= '0;
            AddressBusSel    <= 1'b0;
            RW               <= 1'b0;
            Dout             <= '0;
            LDRDataToDestReg <= '0;
            LDRSel           <= 1'b0;
            Busy             <= 1'b0;
            Done             <= 1'b0;
            Error            <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    Done   <= 1'b0;
                    Error  <= 1'b0;
                    LDRSel <= 1'b0;
                    if (Start && (Opcode == OP_LDR || Opcode == OP_STR)) begin
                        state_r       <= ST_REQ;
                        is_ldr_r      <= (Opcode == OP_LDR);
                        timeout_cnt_r <= TIMEOUT_LOAD;
                        BusReq        <= 1'b1;
                        AddressBusSel <= 1'b1;
                        AddressBus    <= Address;
                        RW            <= (Opcode == OP_LDR);
                        Dout          <= (Opcode == OP_STR) ? Data : '0;
                        Busy          <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        Busy    <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (BusAck) begin
                        if (WAIT_CYCLES != 0) begin
                            state_r    <= ST_WAIT;
                            wait_cnt_r <= WAIT_LOAD;
                            BusReq     <= 1'b0;
                        end else begin
                            state_r       <= ST_DONE;
                            BusReq        <= 1'b0;
                            AddressBusSel <= 1'b0;
                            AddressBus    <= '0;
                            RW            <= 1'b0;
                            Dout          <= '0;
                            Done          <= 1'b1;
                            LDRSel        <= is_ldr_r;
                            if (is_ldr_r) begin
                                LDRDataToDestReg <= Din;
                            end else begin
                                LDRDataToDestReg <= LDRDataToDestReg;
                            end
                        end
                    end else if (timeout_cnt_r == 8'd1) begin
                        // Final REQ cycle without an acknowledge: abort with Error.
                        state_r       <= ST_DONE;
                        BusReq        <= 1'b0;
                        AddressBusSel <= 1'b0;
                        AddressBus    <= '0;
                        RW            <= 1'b0;
                        Dout          <= '0;
                        Done          <= 1'b1;
                        Error         <= 1'b1;
                        LDRSel        <= 1'b0;
                    end else begin
                        state_r       <= ST_REQ;
                        timeout_cnt_r <= timeout_cnt_r - 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_r == 8'd0) begin
                        state_r       <= ST_DONE;
                        AddressBusSel <= 1'b0;
                        AddressBus    <= '0;
                        RW            <= 1'b0;
                        Dout          <= '0;
                        Done          <= 1'b1;
                        LDRSel        <= is_ldr_r;
                        if (is_ldr_r) begin
                            LDRDataToDestReg <= Din;
                        end else begin
                            LDRDataToDestReg <= LDRDataToDestReg;
                        end
                    end else begin
                        state_r    <= ST_WAIT;
                        wait_cnt_r <= wait_cnt_r - 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    Done    <= 1'b0;
                    Error   <= 1'b0;
                    LDRSel  <= 1'b0;
                    Busy    <= 1'b0;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    BusReq        <= 1'b0;
                    AddressBusSel <= 1'b0;
                    AddressBus    <= '0;
                    RW            <= 1'b0;
                    Dout          <= '0;
                    LDRSel        <= 1'b0;
                    Busy          <= 1'b0;
                    Done          <= 1'b0;
                    Error         <= 1'b0;
                end
            endcase
        end
    end

endmodule
